// File: rtl/disp_pkg.sv
// Shared display types and helpers for the 4-digit 7-segment scan path.
// Used by digit_scanner, its interface and the downstream display blocks.
package disp_pkg;

    localparam int DIG_COUNT = 4;

    typedef logic [1:0] dig_sel_t;
    typedef logic [3:0] nibble_t;

    localparam logic [3:0] ANODES_OFF = 4'b1111;

    // Nibble n of a 16-bit display value belongs to digit n.
    function automatic nibble_t pick_nibble(input logic [15:0] val, input dig_sel_t sel);
        nibble_t nib;
        case (sel)
            2'd0:    nib = val[3:0];
            2'd1:    nib = val[7:4];
            2'd2:    nib = val[11:8];
            2'd3:    nib = val[15:12];
            default: nib = val[3:0];
        endcase
        return nib;
    endfunction

    // Active-low one-hot enable for the selected digit.
    function automatic logic [3:0] anode_decode(input dig_sel_t sel);
        logic [3:0] an;
        case (sel)
            2'd0:    an = 4'b1110;
            2'd1:    an = 4'b1101;
            2'd2:    an = 4'b1011;
            2'd3:    an = 4'b0111;
            default: an = ANODES_OFF;
        endcase
        return an;
    endfunction

    // A digit is a leading zero when it and every higher nibble are zero.
    // Digit 0 is never a leading zero so an all-zero value still shows "0".
    function automatic logic lead_zero(input logic [15:0] val, input dig_sel_t sel);
        logic lz;
        case (sel)
            2'd0:    lz = 1'b0;
            2'd1:    lz = (val[15:4] == 12'h000);
            2'd2:    lz = (val[15:8] == 8'h00);
            2'd3:    lz = (val[15:12] == 4'h0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction

endpackage

// File: rtl/digit_scanner_if.sv
// Display-value load port and scan outputs of digit_scanner.
// master: the block that loads values and observes the scan; slave: the scanner.
interface digit_scanner_if;
    import disp_pkg::*;

    logic [15:0] value;
    logic        load;
    dig_sel_t    dig_sel;
    nibble_t     digit;
    logic [3:0]  anodes;
    logic        frame_start;
    logic        pending;

    modport master (
        output value,
        output load,
        input  dig_sel,
        input  digit,
        input  anodes,
        input  frame_start,
        input  pending
    );

    modport slave (
        input  value,
        input  load,
        output dig_sel,
        output digit,
        output anodes,
        output frame_start,
        output pending
    );

endinterface

// File: rtl/scan_prescaler.sv
// Digit-slot timer: counts DIV_CYCLES clocks per slot.
// slot_end marks the last cycle of a slot; in_blank says whether the
// slot position reached on the next edge lies in the anti-ghosting gap,
// so the caller can register its anodes in step with the counter.
module scan_prescaler #(
    parameter int DIV_CYCLES   = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end,
    output logic in_blank
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] tick_cnt_r;
    logic [CW-1:0] tick_nxt_s;
    logic          slot_end_s;
    logic          in_blank_s;

    // Next tick value and the slot flags derived from it.
    always_comb begin
        slot_end_s = (tick_cnt_r == TICK_LAST);
        if (slot_end_s) begin
            tick_nxt_s = {CW{1'b0}};
        end else begin
            tick_nxt_s = tick_cnt_r + CW'(1);
        end
        in_blank_s = (tick_nxt_s < BLANK_END);
    end

    // Slot tick counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= {CW{1'b0}};
        end else begin
            tick_cnt_r <= tick_nxt_s;
        end
    end

    assign slot_end = slot_end_s;
    assign in_blank = in_blank_s;

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed scan controller for the 4-digit 7-segment display.
// Holds the shown value in a shadow register that only changes at frame
// boundaries; a load mid-frame waits in a pending register (last wins).
// All outputs are registered and move together on slot changes.
// Optional build macro: LEADING_ZERO_BLANK_EN keeps the anodes of leading
// zero digits (never digit 0) off for their whole slot.
module digit_scanner
    import disp_pkg::*;
#(
    parameter int DIV_CYCLES   = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic            clk,
    input  logic            rst,
    digit_scanner_if.slave  bus
);

    localparam dig_sel_t LAST_DIG = dig_sel_t'(DIG_COUNT - 1);

    logic        slot_end_s;
    logic        in_blank_s;
    logic        boundary_s;
    dig_sel_t    dig_nxt_s;
    logic [15:0] shadow_nxt_s;
    logic [15:0] pend_val_nxt_s;
    logic        pend_nxt_s;
    nibble_t     digit_nxt_s;
    logic [3:0]  anodes_nxt_s;

    dig_sel_t    dig_sel_r;
    nibble_t     digit_r;
    logic [3:0]  anodes_r;
    logic        frame_start_r;
    logic        pending_r;
    logic [15:0] shadow_r;
    logic [15:0] pend_val_r;

    scan_prescaler #(
        .DIV_CYCLES   (DIV_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .slot_end (slot_end_s),
        .in_blank (in_blank_s)
    );

    // Next digit, buffered value and anode pattern for the coming edge.
    always_comb begin
        boundary_s = slot_end_s && (dig_sel_r == LAST_DIG);

        if (slot_end_s) begin
            dig_nxt_s = dig_sel_r + 2'd1;
        end else begin
            dig_nxt_s = dig_sel_r;
        end

        shadow_nxt_s   = shadow_r;
        pend_val_nxt_s = pend_val_r;
        pend_nxt_s     = pending_r;
        if (bus.load && boundary_s) begin
            // Load landing on the boundary is shown immediately.
            shadow_nxt_s = bus.value;
            pend_nxt_s   = 1'b0;
        end else if (bus.load) begin
            pend_val_nxt_s = bus.value;
            pend_nxt_s     = 1'b1;
        end else if (boundary_s && pending_r) begin
            shadow_nxt_s = pend_val_r;
            pend_nxt_s   = 1'b0;
        end else begin
            pend_nxt_s = pending_r;
        end

        // Use the post-edge shadow so a new frame's first digit is coherent.
        digit_nxt_s = pick_nibble(shadow_nxt_s, dig_nxt_s);

        if (in_blank_s) begin
            anodes_nxt_s = ANODES_OFF;
`ifdef LEADING_ZERO_BLANK_EN
        end else if (lead_zero(shadow_nxt_s, dig_nxt_s)) begin
            anodes_nxt_s = ANODES_OFF;
`endif
        end else begin
            anodes_nxt_s = anode_decode(dig_nxt_s);
        end
    end

    // Registered scan state and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_sel_r     <= 2'd0;
            digit_r       <= 4'd0;
            anodes_r      <= ANODES_OFF;
            frame_start_r <= 1'b0;
            pending_r     <= 1'b0;
            shadow_r      <= 16'h0000;
            pend_val_r    <= 16'h0000;
        end else begin
            dig_sel_r     <= dig_nxt_s;
            digit_r       <= digit_nxt_s;
            anodes_r      <= anodes_nxt_s;
            frame_start_r <= boundary_s;
            pending_r     <= pend_nxt_s;
            shadow_r      <= shadow_nxt_s;
            pend_val_r    <= pend_val_nxt_s;
        end
    end

    assign bus.dig_sel     = dig_sel_r;
    assign bus.digit       = digit_r;
    assign bus.anodes      = anodes_r;
    assign bus.frame_start = frame_start_r;
    assign bus.pending     = pending_r;

endmodule

// File: tb/tb_digit_scanner.sv
// Bench for digit_scanner (DIV_CYCLES=8, BLANK_CYCLES=2).
// Reference model tracks time since reset and derives slot, digit and
// anodes arithmetically; shadow/pending follow the load rules.
module tb_digit_scanner;
    import disp_pkg::*;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    digit_scanner_if bus ();

    digit_scanner #(
        .DIV_CYCLES   (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    int unsigned m_t      = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic [15:0] m_pval   = 16'h0000;
    logic        m_pend   = 1'b0;
    logic        m_fs     = 1'b0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge();
        logic bnd;
        if (rst) begin
            m_t      = 0;
            m_shadow = 16'h0000;
            m_pval   = 16'h0000;
            m_pend   = 1'b0;
            m_fs     = 1'b0;
        end else begin
            bnd = ((m_t % FRAME) == FRAME - 1);
            if (bus.load && bnd) begin
                m_shadow = bus.value;
                m_pend   = 1'b0;
            end else if (bus.load) begin
                m_pval = bus.value;
                m_pend = 1'b1;
            end else if (bnd && m_pend) begin
                m_shadow = m_pval;
                m_pend   = 1'b0;
            end
            m_fs = bnd;
            m_t++;
        end
    endfunction

    task automatic check_outputs();
        int         sel;
        int         tick;
        logic [3:0] ea;
        logic [15:0] ed;
        sel  = (m_t / DIV) % 4;
        tick = m_t % DIV;
        ed   = (m_shadow >> (4 * sel)) & 16'h000F;
        if (tick < BLANK) begin
            ea = 4'b1111;
        end else begin
            ea = ~(4'b0001 << sel);
`ifdef LEADING_ZERO_BLANK_EN
            if (sel != 0 && (m_shadow >> (4 * sel)) == 16'h0000) ea = 4'b1111;
`endif
        end
        check_val("dig_sel",     16'(bus.dig_sel),     16'(sel));
        check_val("digit",       16'(bus.digit),       ed);
        check_val("anodes",      16'(bus.anodes),      16'(ea));
        check_val("frame_start", 16'(bus.frame_start), 16'(m_fs));
        check_val("pending",     16'(bus.pending),     16'(m_pend));
    endtask

    task automatic cycle(input logic r, input logic ld, input logic [15:0] v);
        rst       = r;
        bus.load  = ld;
        bus.value = v;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000);
    endtask

    // Advance until the frame phase equals ph; bounded by one frame.
    task automatic run_to_phase(input int ph);
        for (int i = 0; i < FRAME + 1 && (m_t % FRAME) != ph; i++) cycle(1'b0, 1'b0, 16'h0000);
        check_val("phase_timeout", 16'(m_t % FRAME), 16'(ph));
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.value = 16'h0000;

        // Reset held 3 cycles, then free-run
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000);
        idle(40);

        // Mid-frame load waits for the boundary
        cycle(1'b0, 1'b1, 16'h1234);
        idle(2 * FRAME);

        // Two loads in one frame: last wins
        run_to_phase(2);
        cycle(1'b0, 1'b1, 16'hAAAA);
        idle(4);
        cycle(1'b0, 1'b1, 16'hBEEF);
        idle(2 * FRAME);

        // Load on the boundary edge goes straight to the shadow
        run_to_phase(FRAME - 1);
        cycle(1'b0, 1'b1, 16'h5A5A);
        idle(FRAME);

        // Reset with digit 2 active and a value pending
        run_to_phase(1);
        cycle(1'b0, 1'b1, 16'h7777);
        for (int i = 0; i < FRAME && ((m_t / DIV) % 4) != 2; i++) cycle(1'b0, 1'b0, 16'h0000);
        check_val("pend_before_rst", 16'(bus.pending), 16'h0001);
        cycle(1'b1, 1'b0, 16'h0000);
        idle(FRAME + 4);

        // Leading-zero candidate value
        run_to_phase(FRAME - 1);
        cycle(1'b0, 1'b1, 16'h00A0);
        idle(2 * FRAME);

        // Randomized loads and occasional resets
        for (int i = 0; i < 1500; i++) begin
            logic        r;
            logic        ld;
            logic [15:0] v;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 9) == 0);
            v  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            cycle(r, ld, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
